// File: rtl/mul_pkg.sv
// Shared types and sizes for the sequential shift-add multiplier.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package mul_pkg;

   localparam int W     = 16;   // operand / product width
   localparam int STEPS = 16;   // shift-add steps in fixed-latency mode

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HOLD = 2'd2
   } state_t;

endpackage

// File: rtl/s16bit.sv
// 16-bit two-level carry-lookahead adder: 4-bit groups with local lookahead, group P/G feeding a second lookahead level.
// Latency: purely combinational.
// Backpressure: none.
// Ports: a, b - addends; c_0 - carry in; s - 16-bit sum (carry out of bit 15 is not produced).
module s16bit (
   input  logic [15:0] a,
   input  logic [15:0] b,
   input  logic        c_0,
   output logic [15:0] s
);

   logic [15:0] g;    // bit generate
   logic [15:0] p;    // bit propagate
   logic [15:0] c;    // carry into each bit
   logic [2:0]  gg;   // group generate (group 3 never feeds a carry we keep)
   logic [2:0]  gp;   // group propagate
   logic [3:0]  gc;   // carry into each 4-bit group

   assign g = a & b;
   assign p = a ^ b;

   for (genvar gi = 0; gi < 3; gi++) begin : g_grp_pg
      localparam int B = 4 * gi;
      assign gg[gi] = g[B+3]
                    | (p[B+3] & g[B+2])
                    | (p[B+3] & p[B+2] & g[B+1])
                    | (p[B+3] & p[B+2] & p[B+1] & g[B]);
      assign gp[gi] = &p[B+3:B];
   end

   // Second lookahead level: group carries straight from c_0 and group P/G.
   assign gc[0] = c_0;
   assign gc[1] = gg[0] | (gp[0] & c_0);
   assign gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & c_0);
   assign gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
                | (gp[2] & gp[1] & gp[0] & c_0);

   // First lookahead level: bit carries inside each group from its group carry.
   for (genvar gi = 0; gi < 4; gi++) begin : g_grp_c
      localparam int B = 4 * gi;
      assign c[B]   = gc[gi];
      assign c[B+1] = g[B] | (p[B] & gc[gi]);
      assign c[B+2] = g[B+1] | (p[B+1] & g[B]) | (p[B+1] & p[B] & gc[gi]);
      assign c[B+3] = g[B+2] | (p[B+2] & g[B+1]) | (p[B+2] & p[B+1] & g[B])
                    | (p[B+2] & p[B+1] & p[B] & gc[gi]);
   end

   assign s = p ^ c;

endmodule

// File: rtl/mul16_shift_add.sv
// Sequential 16x16 unsigned shift-add multiplier returning (a*b) mod 2^16, one operation in flight.
// Latency: result valid 16 edges after accept (EARLY_EXIT=0) or after max(1, msb(b)+1) edges (EARLY_EXIT=1).
// Backpressure: in_ready only in IDLE; result held in HOLD with out_valid until out_ready is seen at an edge.
// Ports: clk, nrst (async active-low); in_valid/in_ready/a/b operand handshake;
//        out_valid/out_ready/product result handshake; busy high while stepping.
module mul16_shift_add
   import mul_pkg::*;
#(
   parameter bit EARLY_EXIT = 1'b0
) (
   input  logic         clk,
   input  logic         nrst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] product,
   output logic         busy
);

   state_t       state;
   state_t       state_nxt;
   logic [W-1:0] a_reg;
   logic [W-1:0] b_reg;
   logic [W-1:0] acc;
   logic [W-1:0] sum;
   logic [4:0]   cnt;
   logic         last_step;

   // Single adder; the carry out of bit 15 is dropped, giving the mod 2^16 wrap.
   s16bit u_add (
      .a   (acc),
      .b   (a_reg),
      .c_0 (1'b0),
      .s   (sum)
   );

   // The step in progress is the last one on the 16th step, or (early exit)
   // when no multiplier bits remain above the one consumed now.
   assign last_step = (cnt == 5'(STEPS - 1))
                    || (EARLY_EXIT && (b_reg[W-1:1] == '0));

   // State register.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (in_valid)  state_nxt = RUN;
         RUN:     if (last_step) state_nxt = HOLD;
         HOLD:    if (out_ready) state_nxt = IDLE;
         default:                state_nxt = IDLE;
      endcase
   end

   // Handshake outputs decode directly from the state.
   always_comb begin
      in_ready  = 1'b0;
      busy      = 1'b0;
      out_valid = 1'b0;
      case (state)
         IDLE:    in_ready  = 1'b1;
         RUN:     busy      = 1'b1;
         HOLD:    out_valid = 1'b1;
         default: in_ready  = 1'b0;
      endcase
   end

   // Datapath: load on accept, shift-add while running, otherwise hold.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         a_reg <= '0;
         b_reg <= '0;
         acc   <= '0;
         cnt   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_reg <= a;
                  b_reg <= b;
                  acc   <= '0;
                  cnt   <= '0;
               end
            end
            RUN: begin
               if (b_reg[0]) acc <= sum;
               a_reg <= a_reg << 1;
               b_reg <= b_reg >> 1;
               cnt   <= cnt + 5'd1;
            end
            default: begin
               // HOLD: product must stay stable.
            end
         endcase
      end
   end

   // Product stays on acc after HOLD until the next load clears it.
   assign product = acc;

endmodule

// File: tb/tb_mul16_shift_add.sv
// Bench for mul16_shift_add: instance 0 fixed latency, instance 1 early exit.
// A behavioural model predicts handshake outputs and product every cycle;
// directed operations additionally pin products and latencies to literals.
module tb_mul16_shift_add;

   logic        clk = 1'b0;
   logic        nrst = 1'b1;
   logic [1:0]  in_valid_v = 2'b00;
   logic [1:0]  out_ready_v = 2'b11;
   logic [1:0]  in_ready_v;
   logic [1:0]  out_valid_v;
   logic [1:0]  busy_v;
   logic [15:0] a_v [2] = '{16'h0, 16'h0};
   logic [15:0] b_v [2] = '{16'h0, 16'h0};
   logic [15:0] prod_v [2];

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   mul16_shift_add #(.EARLY_EXIT(1'b0)) dut0 (
      .clk(clk), .nrst(nrst),
      .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
      .a(a_v[0]), .b(b_v[0]),
      .out_valid(out_valid_v[0]), .out_ready(out_ready_v[0]),
      .product(prod_v[0]), .busy(busy_v[0])
   );

   mul16_shift_add #(.EARLY_EXIT(1'b1)) dut1 (
      .clk(clk), .nrst(nrst),
      .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
      .a(a_v[1]), .b(b_v[1]),
      .out_valid(out_valid_v[1]), .out_ready(out_ready_v[1]),
      .product(prod_v[1]), .busy(busy_v[1])
   );

   task automatic check(input string nm, input int idx, input int unsigned got, input int unsigned exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s dut%0d t=%0t got=0x%0h expected=0x%0h", nm, idx, $time, got, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   // phase: 0 idle, 1 computing, 2 result offered
   int          m_phase [2] = '{0, 0};
   int          m_left  [2] = '{0, 0};
   logic [15:0] m_exp   [2] = '{16'h0, 16'h0};
   logic [15:0] m_prod  [2] = '{16'h0, 16'h0};

   function automatic int exp_lat(input int early, input logic [15:0] bv);
      int k;
      k = 0;
      if (early == 0) return 16;
      for (int j = 0; j < 16; j++) if (bv[j]) k = j + 1;
      return (k < 1) ? 1 : k;
   endfunction

   always @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         for (int i = 0; i < 2; i++) begin
            m_phase[i] = 0; m_left[i] = 0; m_prod[i] = 16'h0;
         end
      end else begin
         for (int i = 0; i < 2; i++) begin
            case (m_phase[i])
               0: if (in_valid_v[i]) begin
                     m_phase[i] = 1;
                     m_left[i]  = exp_lat(i, b_v[i]);
                     m_exp[i]   = 16'((32'(a_v[i]) * 32'(b_v[i])) & 32'hFFFF);
                  end
               1: begin
                     m_left[i]--;
                     if (m_left[i] == 0) begin
                        m_phase[i] = 2;
                        m_prod[i]  = m_exp[i];
                     end
                  end
               default: if (out_ready_v[i]) m_phase[i] = 0;
            endcase
         end
      end
   end

   // Per-cycle compare against the model.
   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         check("cmp_in_ready", i, in_ready_v[i], (m_phase[i] == 0) ? 1 : 0);
         check("cmp_busy", i, busy_v[i], (m_phase[i] == 1) ? 1 : 0);
         check("cmp_out_valid", i, out_valid_v[i], (m_phase[i] == 2) ? 1 : 0);
         if (m_phase[i] != 1) check("cmp_product", i, prod_v[i], m_prod[i]);
      end
   end

   // ---------------- directed stimulus ----------------
   int e0;

   task automatic wait_result(input int idx, input string nm, output bit ok);
      int n;
      n = 0;
      while (!out_valid_v[idx] && n < 40) begin
         @(negedge clk);
         n++;
      end
      ok = out_valid_v[idx];
      if (!ok) check({nm, "_timeout"}, idx, 0, 1);
   endtask

   task automatic do_op(input int idx, input logic [15:0] av, input logic [15:0] bv,
                        input logic [15:0] ep, input int el, input string nm);
      bit ok;
      @(negedge clk);
      a_v[idx] = av; b_v[idx] = bv;
      in_valid_v[idx] = 1'b1;
      out_ready_v[idx] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid_v[idx] = 1'b0;
      e0 = cyc;
      wait_result(idx, nm, ok);
      if (ok) begin
         check({nm, "_latency"}, idx, cyc - e0, el);
         check({nm, "_product"}, idx, prod_v[idx], ep);
         @(negedge clk);
         check({nm, "_valid_1cyc"}, idx, out_valid_v[idx], 0);
         check({nm, "_ready_back"}, idx, in_ready_v[idx], 1);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog t=%0t got=running expected=finished", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      bit ok;
      logic [15:0] held;
      #2 nrst = 1'b0;
      #1;
      check("rst_in_ready", 0, in_ready_v[0], 1);
      check("rst_out_valid", 0, out_valid_v[0], 0);
      check("rst_busy", 0, busy_v[0], 0);
      check("rst_product", 0, prod_v[0], 0);
      repeat (3) @(posedge clk);
      #2 nrst = 1'b1;

      do_op(0, 16'd3,    16'd5,    16'h000F, 16, "basic");
      do_op(0, 16'hFFFF, 16'hFFFF, 16'h0001, 16, "wrap_ffff");
      do_op(0, 16'h00FF, 16'h0101, 16'hFFFF, 16, "wrap_00ff");
      do_op(1, 16'h1234, 16'h0000, 16'h0000, 1,  "early_b0");
      do_op(1, 16'h0011, 16'h0008, 16'h0088, 4,  "early_b8");
      do_op(1, 16'hFFFF, 16'hFFFF, 16'h0001, 16, "early_full");
      do_op(1, 16'h0005, 16'h0001, 16'h0005, 1,  "early_b1");
      do_op(0, 16'h1234, 16'h0000, 16'h0000, 16, "fixed_b0");

      // Backpressure: result held for 5 cycles with out_ready low.
      @(negedge clk);
      a_v[0] = 16'h0102; b_v[0] = 16'h0003;
      in_valid_v[0] = 1'b1; out_ready_v[0] = 1'b0;
      @(posedge clk);
      @(negedge clk);
      in_valid_v[0] = 1'b0;
      wait_result(0, "bp", ok);
      if (ok) begin
         held = prod_v[0];
         check("bp_product", 0, held, 16'h0306);
         for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_valid_held", 0, out_valid_v[0], 1);
            check("bp_product_held", 0, prod_v[0], 16'h0306);
            check("bp_in_ready_low", 0, in_ready_v[0], 0);
         end
         out_ready_v[0] = 1'b1;
         @(negedge clk);
         check("bp_release_idle", 0, in_ready_v[0], 1);
         check("bp_product_kept", 0, prod_v[0], 16'h0306);
      end

      // Ignored input while running; second request accepted only from IDLE.
      @(negedge clk);
      a_v[0] = 16'd7; b_v[0] = 16'd9;
      in_valid_v[0] = 1'b1; out_ready_v[0] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      a_v[0] = 16'd2; b_v[0] = 16'd2;
      e0 = cyc;
      wait_result(0, "ign", ok);
      if (ok) begin
         check("ign_latency", 0, cyc - e0, 16);
         check("ign_product", 0, prod_v[0], 16'h003F);
         @(negedge clk);
         check("ign_idle_after_hold", 0, in_ready_v[0], 1);
         @(negedge clk);
         check("ign_second_accept", 0, busy_v[0], 1);
         in_valid_v[0] = 1'b0;
         e0 = cyc;
         wait_result(0, "ign2", ok);
         if (ok) begin
            check("ign2_latency", 0, cyc - e0, 16);
            check("ign2_product", 0, prod_v[0], 16'h0004);
         end
      end

      // Reset mid-operation.
      @(negedge clk);
      a_v[0] = 16'h1111; b_v[0] = 16'h0003;
      in_valid_v[0] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid_v[0] = 1'b0;
      repeat (7) @(negedge clk);
      check("mid_busy_before_rst", 0, busy_v[0], 1);
      @(posedge clk);
      #2 nrst = 1'b0;
      #1;
      check("arst_out_valid", 0, out_valid_v[0], 0);
      check("arst_product", 0, prod_v[0], 0);
      check("arst_in_ready", 0, in_ready_v[0], 1);
      check("arst_busy", 0, busy_v[0], 0);
      repeat (2) @(posedge clk);
      #2 nrst = 1'b1;
      do_op(0, 16'd6, 16'd7, 16'h002A, 16, "after_rst");

      repeat (2) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mul16_shift_add.md
Name: mul16_shift_add

Overview:
- Sequential 16x16 unsigned multiplier; returns the low 16 bits of the product (mod 2^16).
- Sits directly upstream of the 16-bit two-level carry-lookahead adder (s16bit) and is its consumer in the datapath.
- Each cycle it feeds the adder the accumulator and a shifted multiplicand, then registers the sum.
- Valid/ready handshake on both input and output sides; one operation in flight.

Parameters:
- EARLY_EXIT, 0, 1 = finish as soon as the remaining multiplier bits are all zero; 0 = fixed 16-step latency.

Ports:
- clk  input  1  single clock, rising edge
- nrst  input  1  asynchronous active-low reset
- in_valid  input  1  operands a, b valid
- in_ready  output  1  block can accept operands
- a  input  16  multiplicand
- b  input  16  multiplier
- out_valid  output  1  product valid
- out_ready  input  1  consumer takes product
- product  output  16  (a*b) mod 2^16
- busy  output  1  high in RUN

Behaviour:
- Clock and reset: one clock, clk. Reset nrst is asynchronous and active-low.
- While nrst=0:
  - state=IDLE; a_reg, b_reg, acc, cnt all 0.
  - product=0, out_valid=0, busy=0, in_ready=1.
  - Reset asserted mid-RUN or mid-HOLD aborts the operation. No output is produced, and the block is IDLE on release.
- States: IDLE, RUN, HOLD.
  - in_ready = (state==IDLE)
  - busy = (state==RUN)
  - out_valid = (state==HOLD)
  - product = acc, a registered value. It is stable throughout HOLD and keeps its last value after HOLD until the next load.
- IDLE:
  - When in_valid=1 at an edge: a_reg<=a, b_reg<=b, acc<=0, cnt<=0, go to RUN.
  - When in_valid=0: no register changes.
- RUN, each edge:
  - acc <= b_reg[0] ? sum : acc, where sum comes from s16bit(acc, a_reg, c_0=0). Carry-out beyond bit 15 is discarded (wrap).
  - a_reg <= a_reg<<1, zero-fill; bits shifted out are lost.
  - b_reg <= b_reg>>1
  - cnt <= cnt+1 (5-bit counter)
  - Go to HOLD when cnt==15 (16th step).
  - If EARLY_EXIT=1, also go to HOLD when (b_reg>>1)==0 on this step.
- HOLD:
  - out_valid=1, held until out_ready=1 at an edge, then go to IDLE.
  - If out_ready is already 1 on the first HOLD cycle, HOLD lasts exactly one cycle.
- Input during RUN/HOLD: in_ready=0, so in_valid is ignored and operands are not sampled. No back-to-back acceptance in the HOLD->IDLE cycle: the next accept is the earliest edge in IDLE.
- Latency (accept edge E0):
  - Fixed mode (EARLY_EXIT=0): out_valid rises after edge E0+16.
  - EARLY_EXIT=1: out_valid rises after edge E0+k, where k = max(1, index of highest set bit of b + 1).
  - With out_ready tied high, throughput is one result per 18 cycles in fixed mode.
- a=0 or b=0: product 0. In fixed mode all 16 steps are still executed.
- Adder use: s16bit is purely combinational, with a single-cycle path from acc/a_reg to acc. No pipelining inside the block.

Decomposition:
- Shared package mul_pkg:
  - typedef state_t enum {IDLE, RUN, HOLD}
  - localparam W=16
  - localparam STEPS=16
- Sub-module: instance of the existing s16bit (c_0 tied 0) as the sole adder. No other sub-modules; shift registers and FSM are in this block.
- Expected size ~150 lines RTL.

Test Plan:
- Basic: EARLY_EXIT=0, a=3, b=5, out_ready=1 -> product=0x000F, out_valid high exactly 16 edges after accept, for 1 cycle; in_ready back at 1 the next cycle.
- Wrap: a=0xFFFF, b=0xFFFF -> product=0x0001. Also a=0x00FF, b=0x0101 -> product=0xFFFF.
- Zero/early exit:
  - EARLY_EXIT=1, a=0x1234, b=0 -> product=0, latency 1.
  - EARLY_EXIT=1, b=0x0008, a=0x0011 -> product=0x0088, latency 4.
  - EARLY_EXIT=0, b=0 -> latency 16.
- Backpressure: out_ready=0 for 5 cycles in HOLD -> out_valid and product stay constant, in_ready=0. Raising out_ready -> IDLE next edge.
- Ignored input: accept (7,9), then in_valid=1 with (2,2) during RUN -> result 0x003F, and the (2,2) request is accepted only once back in IDLE.
- Reset mid-op: pull nrst low 8 cycles after accept -> out_valid=0, product=0, in_ready=1 immediately (asynchronous). After release, a fresh (6,7) yields 0x002A.
